// File: rtl/gc_conf_defs.sv
// Shared definitions for the Global Controller configuration loader:
// component select codes, FSM state encoding and the request one-hot helper.
package gc_conf_defs;

    localparam int NUM_COMP     = 6;
    localparam int SELECT_WIDTH = 3;

    // Select codes of the conf_ack multiplexer, in configuration order.
    localparam logic [SELECT_WIDTH-1:0] CS_IDLE    = 3'd0;
    localparam logic [SELECT_WIDTH-1:0] CS_CLKGEN  = 3'd1;
    localparam logic [SELECT_WIDTH-1:0] CS_INIT    = 3'd2;
    localparam logic [SELECT_WIDTH-1:0] CS_STRIDE  = 3'd3;
    localparam logic [SELECT_WIDTH-1:0] CS_MINMAX  = 3'd4;
    localparam logic [SELECT_WIDTH-1:0] CS_CTRLGEN = 3'd5;
    localparam logic [SELECT_WIDTH-1:0] CS_REINIT  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_NEXT = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    function automatic logic [NUM_COMP-1:0] comp_onehot(input logic [SELECT_WIDTH-1:0] code);
        comp_onehot = '0;
        if (code != CS_IDLE) begin
            comp_onehot = NUM_COMP'(1) << (code - 3'd1);
        end
    endfunction

endpackage

// File: rtl/gc_conf_loader_fsm_if.sv
// Control/handshake bundle between the configuration loader and its environment.
interface gc_conf_loader_fsm_if #(
    parameter int SELECT_WIDTH = gc_conf_defs::SELECT_WIDTH,
    parameter int NUM_COMP     = gc_conf_defs::NUM_COMP
);
    logic                    start;
    logic                    abort;
    logic [NUM_COMP-1:0]     comp_mask;
    logic                    conf_ack;
    logic [SELECT_WIDTH-1:0] conf_sel;
    logic [NUM_COMP-1:0]     conf_req;
    logic                    busy;
    logic                    done;
    logic                    error;
    logic [SELECT_WIDTH-1:0] err_comp;

    modport master (
        output start, abort, comp_mask, conf_ack,
        input  conf_sel, conf_req, busy, done, error, err_comp
    );

    modport slave (
        input  start, abort, comp_mask, conf_ack,
        output conf_sel, conf_req, busy, done, error, err_comp
    );
endinterface

// File: rtl/gc_next_comp_finder.sv
// Priority encoder: code (bit index + 1) of the lowest set mask bit at or above
// bit position from_idx, i.e. strictly after component code from_idx.
module gc_next_comp_finder #(
    parameter int NUM_COMP     = gc_conf_defs::NUM_COMP,
    parameter int SELECT_WIDTH = gc_conf_defs::SELECT_WIDTH
) (
    input  logic [NUM_COMP-1:0]     mask,
    input  logic [SELECT_WIDTH-1:0] from_idx,
    output logic [SELECT_WIDTH-1:0] next_idx,
    output logic                    found
);
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        for (int i = NUM_COMP - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from_idx))) begin
                next_idx = SELECT_WIDTH'(i + 1);
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/gc_conf_loader_fsm.sv
// Configuration loader sequencer: walks the enabled components in fixed order,
// pulsing a request, selecting the ack mux and waiting for ack with a timeout.
module gc_conf_loader_fsm #(
    parameter int SELECT_WIDTH = gc_conf_defs::SELECT_WIDTH,
    parameter int NUM_COMP     = gc_conf_defs::NUM_COMP,
    parameter int TIMER_WIDTH  = 8,
    parameter int TIMEOUT      = 200
) (
    input  logic                 clk,
    input  logic                 reset,
    gc_conf_loader_fsm_if.slave  bus
);
    import gc_conf_defs::*;

    state_t                  state, state_nxt;
    logic [SELECT_WIDTH-1:0] idx, idx_nxt;
    logic [NUM_COMP-1:0]     mask, mask_nxt;
    logic [TIMER_WIDTH-1:0]  timer, timer_nxt;
    logic [SELECT_WIDTH-1:0] fin_from, fin_idx;
    logic [NUM_COMP-1:0]     fin_mask;
    logic                    fin_found;
    logic                    timed_out;
    logic [SELECT_WIDTH-1:0] conf_sel_nxt, err_comp_nxt;
    logic [NUM_COMP-1:0]     conf_req_nxt;

    // From IDLE/ERR search the incoming mask from the bottom; from NEXT search
    // the latched mask above the component just finished.
    assign fin_mask  = (state == ST_NEXT) ? mask : bus.comp_mask;
    assign fin_from  = (state == ST_NEXT) ? idx  : '0;
    assign timed_out = (timer == TIMER_WIDTH'(TIMEOUT - 1));

    gc_next_comp_finder #(
        .NUM_COMP     (NUM_COMP),
        .SELECT_WIDTH (SELECT_WIDTH)
    ) u_finder (
        .mask     (fin_mask),
        .from_idx (fin_from),
        .next_idx (fin_idx),
        .found    (fin_found)
    );

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        mask_nxt  = mask;
        timer_nxt = timer;

        case (state)
            ST_IDLE, ST_ERR: begin
                if (bus.start) begin
                    mask_nxt = bus.comp_mask;
                    if (fin_found) begin
                        idx_nxt   = fin_idx;
                        state_nxt = ST_REQ;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                timer_nxt = timer + 1'b1;
                // Ack is checked first so a coincident ack beats the timeout.
                if (bus.conf_ack) begin
                    state_nxt = ST_NEXT;
                end else if (timed_out) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_NEXT: begin
                mask_nxt = mask & ~comp_onehot(idx);
                if (fin_found) begin
                    idx_nxt   = fin_idx;
                    state_nxt = ST_REQ;
                end else begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (state_nxt == ST_REQ) begin
            timer_nxt = '0;
        end

        if (bus.abort) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
            mask_nxt  = '0;
            timer_nxt = '0;
        end

        // Outputs are registered, so they are derived from the next state.
        conf_sel_nxt = ((state_nxt == ST_REQ) || (state_nxt == ST_WAIT)) ? idx_nxt : CS_IDLE;
        conf_req_nxt = (state_nxt == ST_REQ) ? comp_onehot(idx_nxt) : '0;
        err_comp_nxt = '0;
        if (state_nxt == ST_ERR) begin
            err_comp_nxt = (state == ST_WAIT) ? idx : bus.err_comp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            idx          <= '0;
            mask         <= '0;
            timer        <= '0;
            bus.conf_sel <= '0;
            bus.conf_req <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.error    <= 1'b0;
            bus.err_comp <= '0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            mask         <= mask_nxt;
            timer        <= timer_nxt;
            bus.conf_sel <= conf_sel_nxt;
            bus.conf_req <= conf_req_nxt;
            bus.busy     <= (state_nxt == ST_REQ) || (state_nxt == ST_WAIT) || (state_nxt == ST_NEXT);
            bus.done     <= (state_nxt == ST_DONE);
            bus.error    <= (state_nxt == ST_ERR);
            bus.err_comp <= err_comp_nxt;
        end
    end
endmodule

// File: tb/tb_gc_conf_loader_fsm.sv
// Scoreboard bench for gc_conf_loader_fsm: a timing model predicts request,
// done and error events per sequence; a negedge monitor pops and compares them.
module tb_gc_conf_loader_fsm;
    localparam int TIMEOUT = 200;

    typedef struct {
        int kind;   // 0 = request pulse, 1 = done pulse, 2 = error rise
        int cyc;
        int val;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gc_conf_loader_fsm_if bus ();

    gc_conf_loader_fsm #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ev_t exp_q[$];
    int  cyc       = 0;
    int  checks    = 0;
    int  passes    = 0;
    int  ack_delay = 0;
    int  ack_at    = -1;
    bit  ack_hold  = 1'b0;
    bit  mon_en    = 1'b0;
    bit  err_prev  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Component responder: ack a fixed number of cycles after each request.
    always @(posedge clk) begin
        #1;
        bus.conf_ack = ack_hold || (ack_at == cyc);
    end

    task automatic chk(input string name, input bit ok, input int act, input int req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic take(input int kind, input int val);
        ev_t e;
        int  code;
        if (exp_q.size() == 0) begin
            chk($sformatf("unexpected event kind %0d", kind), 1'b0, val, -1);
            return;
        end
        e = exp_q.pop_front();
        chk($sformatf("event kind %0d (want %0d) at cycle %0d (want %0d)", kind, e.kind, cyc, e.cyc),
            (kind == e.kind) && (cyc == e.cyc) && (val == e.val), val, e.val);
        if (kind == 0 && e.kind == 0) begin
            code = 0;
            for (int i = 0; i < 6; i++) if (e.val == (1 << i)) code = i + 1;
            chk("conf_sel at request", int'(bus.conf_sel) == code, int'(bus.conf_sel), code);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.conf_req != '0) begin
                take(0, int'(bus.conf_req));
                chk("busy at request", bus.busy == 1'b1, int'(bus.busy), 1);
                if (ack_delay > 0) ack_at <= cyc + ack_delay;
            end
            if (bus.done) begin
                take(1, 0);
                chk("busy at done", bus.busy == 1'b0, int'(bus.busy), 0);
            end
            if (bus.error && !err_prev) begin
                take(2, int'(bus.err_comp));
                chk("busy at error", bus.busy == 1'b0, int'(bus.busy), 0);
            end
            err_prev <= bus.error;
        end
    end

    task automatic push(input int k, input int c, input int v, input int cut);
        ev_t e;
        if (c <= cut) begin
            e.kind = k;
            e.cyc  = c;
            e.val  = v;
            exp_q.push_back(e);
        end
    endtask

    // Each enabled component costs REQ + (d-1) WAIT + ack cycle + NEXT = d+2
    // cycles; an ack later than TIMEOUT WAIT cycles means error TIMEOUT cycles
    // after WAIT begins.
    task automatic model(input logic [5:0] m, input int d, input int c0, input int cut);
        int r;
        bit stopped;
        r = c0 + 1;
        stopped = 1'b0;
        if (m == 6'd0) begin
            push(1, c0 + 1, 0, cut);
        end else begin
            for (int i = 0; i < 6 && !stopped; i++) begin
                if (m[i]) begin
                    push(0, r, 1 << i, cut);
                    if (d >= 1 && d <= TIMEOUT) r = r + d + 2;
                    else begin
                        push(2, r + 1 + TIMEOUT, i + 1, cut);
                        stopped = 1'b1;
                    end
                end
            end
            if (!stopped) push(1, r, 0, cut);
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 2000 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() > 0) begin
            chk("events still pending after cycle budget", 1'b0, exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic run_seq(input logic [5:0] m, input int d, input bit hold, input int poke);
        int c0;
        ack_delay = hold ? 0 : d;
        ack_hold  = hold;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.comp_mask = m;
        c0 = cyc;
        model(m, hold ? 1 : d, c0, 1 << 30);
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (poke > 0) begin
            repeat (poke) @(posedge clk);
            #1;
            bus.start = 1'b1;
            bus.comp_mask = 6'h3f;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        wait_drain();
        ack_hold = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_abort(input bit use_reset);
        int c0;
        int a;
        ack_delay = 5;
        ack_hold  = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.comp_mask = 6'h3f;
        c0 = cyc;
        a = c0 + 1 + 2 * (5 + 2) + 2;   // second WAIT cycle of component 3
        model(6'h3f, 5, c0, a);
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 0; k < 200 && cyc != a; k++) begin
            @(posedge clk); #1;
        end
        if (use_reset) reset = 1'b1;
        else bus.abort = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.abort = 1'b0;
        @(negedge clk);
        chk(use_reset ? "outputs after reset" : "outputs after abort",
            {bus.conf_sel, bus.conf_req, bus.busy, bus.done, bus.error, bus.err_comp} == '0,
            int'({bus.conf_sel, bus.conf_req, bus.busy, bus.done, bus.error, bus.err_comp}), 0);
        chk("events before abort consumed", exp_q.size() == 0, exp_q.size(), 0);
        exp_q.delete();
        repeat (30) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.comp_mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset conf_sel", bus.conf_sel == '0, int'(bus.conf_sel), 0);
        chk("reset conf_req", bus.conf_req == '0, int'(bus.conf_req), 0);
        chk("reset busy", bus.busy == 1'b0, int'(bus.busy), 0);
        chk("reset done", bus.done == 1'b0, int'(bus.done), 0);
        chk("reset error", bus.error == 1'b0, int'(bus.error), 0);
        chk("reset err_comp", bus.err_comp == '0, int'(bus.err_comp), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;

        run_seq(6'h3f, 1, 1'b0, 0);
        run_seq(6'b010010, 5, 1'b0, 0);
        run_seq(6'b000000, 1, 1'b0, 0);
        run_seq(6'b000011, 1, 1'b1, 0);

        run_seq(6'b000100, 0, 1'b0, 0);
        chk("error sticky", bus.error == 1'b1, int'(bus.error), 1);
        chk("err_comp held", int'(bus.err_comp) == 3, int'(bus.err_comp), 3);
        chk("busy low in error", bus.busy == 1'b0, int'(bus.busy), 0);
        run_seq(6'b000001, 1, 1'b0, 0);
        chk("error cleared by start", bus.error == 1'b0, int'(bus.error), 0);

        run_seq(6'b000001, TIMEOUT, 1'b0, 0);
        run_seq(6'b000010, TIMEOUT + 1, 1'b0, 0);
        chk("late ack still errors", int'(bus.err_comp) == 2, int'(bus.err_comp), 2);

        run_seq(6'b000011, 3, 1'b0, 2);
        run_abort(1'b0);
        run_abort(1'b1);

        for (int n = 0; n < 10; n++) begin
            run_seq(6'($urandom_range(0, 63)), int'($urandom_range(1, 6)), bit'($urandom_range(0, 1)), 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/gc_conf_loader_fsm.md
Name: gc_conf_loader_fsm

Overview:
Configuration loader sequencer of the Global Controller. It configures up to six components in a fixed order: clock generator, initializer, stride selector, minmax comparator matrix, control signal generator, reinitializer. For each component it issues a one-cycle request, drives the select code of the conf_ack multiplexer, and waits for the muxed acknowledge. Per-component timeout and skip mask are included.

Parameters:
SELECT_WIDTH, 3, width of conf_sel (component codes 1..6, 0 = idle)
NUM_COMP, 6, number of configurable components (fixed at 6 in this revision)
TIMER_WIDTH, 8, width of the acknowledge timeout counter
TIMEOUT, 200, WAIT cycles without ack before error (1 .. 2^TIMER_WIDTH-1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a load sequence; sampled only in IDLE or ERR
abort  input  1  return to IDLE next cycle from any state; no done
comp_mask  input  NUM_COMP  bit i=1 means configure component i+1; latched on accepted start
conf_ack  input  1  muxed acknowledge from the conf_ack select mux
conf_sel  output  SELECT_WIDTH  select code to the conf_ack mux
conf_req  output  NUM_COMP  one-hot, one-cycle request to component i+1
busy  output  1  high in REQ, WAIT, NEXT
done  output  1  one-cycle pulse when sequence completes
error  output  1  sticky timeout flag
err_comp  output  SELECT_WIDTH  code of the component that timed out

Behaviour:
- All outputs registered. Reset state IDLE: conf_sel=0, conf_req=0, busy=0, done=0, error=0, err_comp=0, timer=0, mask register=0.
- States: IDLE, REQ, WAIT, NEXT, DONE, ERR.
- IDLE: conf_sel=0. start=1 latches comp_mask. Mask==0 goes to DONE. Otherwise idx = lowest set bit + 1, go to REQ.
- REQ (1 cycle): conf_sel=idx, conf_req[idx-1]=1, timer cleared. Go to WAIT.
- WAIT: conf_sel=idx held, conf_req=0, timer increments each cycle.
  - conf_ack=1 goes to NEXT.
  - Otherwise, timer==TIMEOUT-1 goes to ERR with err_comp=idx.
  - If ack and timeout coincide, ack wins.
- conf_ack is ignored in every state except WAIT, including a same-cycle ack during REQ.
- NEXT (1 cycle): conf_sel=0, which gives a guard gap so a stale ack is never attributed to the next component. Clear mask bit idx-1. If any higher bit remains set, idx = next set bit and go to REQ. Otherwise go to DONE.
- DONE (1 cycle): done=1, busy=0. Go to IDLE.
- ERR: error=1, err_comp held, conf_sel=0, busy=0.
  - start=1 clears error and err_comp, then behaves as in IDLE with the new mask.
  - abort goes to IDLE and clears error.
- abort has priority over every transition; the next state is IDLE, all outputs take reset values, and no done pulse is issued.
- start while busy is ignored. Reset mid-sequence behaves as abort.
- Latency with immediate ack: 3 cycles per enabled component. With start at cycle 0 and all 6 enabled:
  - REQ for component k at cycle 3k-2.
  - done high at cycle 19.
- Empty mask: done high at cycle 1.

Decomposition:
- Shared package/include gc_conf_defs: component select codes (CS_IDLE=0 … CS_REINIT=6), state encodings, NUM_COMP, SELECT_WIDTH.
- Sub-module gc_next_comp_finder: combinational priority encoder returning the next set mask bit above the current index plus a valid flag. It is used in IDLE and NEXT.
- The conf_ack select mux is instantiated in the integration top level, not in this block.

Test Plan:
- Mask 6'b111111, ack 1 cycle after each REQ:
  - conf_sel sequence 1,1,0,2,2,0,…,6,6,0.
  - conf_req pulses 000001…100000 at cycles 1,4,7,10,13,16.
  - done=1 at cycle 19, error=0.
- Mask 6'b010010 (components 2 and 5), ack delayed 5 cycles: only conf_req[1] and conf_req[4] pulse, conf_sel never 1,3,4,6, done once.
- Mask 6'b000100, ack never asserted, TIMEOUT=200:
  - error=1 and err_comp=3 exactly 200 cycles after entering WAIT.
  - busy=0, no done.
  - A new start with mask 6'b000001 clears error.
- Mask 0, start at cycle 0: done=1 at cycle 1, conf_req never asserted, busy never asserted.
- Stale ack: conf_ack held high throughout with mask 6'b000011:
  - Ack during REQ is ignored, each component still needs REQ→WAIT.
  - done at cycle 7.
  - Ack coinciding with timer==TIMEOUT-1 proceeds to NEXT, not ERR.
- Mid-sequence events:
  - abort asserted in WAIT of component 3: next cycle IDLE, all outputs 0, no done.
  - Same scenario with reset instead of abort gives an identical result.
  - start during busy has no effect on the sequence.
